// File: rtl/text_grid_ram.sv
// Row/column character store with automatic clear sweep, CR/LF/BS-aware append
// cursor, row-0 tap outputs and a one-cycle drop indicator for rejected writes.
module text_grid_ram #(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           ROWS        = 4,
  parameter int unsigned           COLS        = 32,
  parameter int unsigned           TAPS        = 2,
  parameter logic [DATA_WIDTH-1:0] FILL        = '0,
  parameter bit                    FILTER_CTRL = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       we,
  input  logic [$clog2(ROWS)-1:0]    w_row,
  input  logic [$clog2(COLS)-1:0]    w_col,
  input  logic [DATA_WIDTH-1:0]      din,
  input  logic                       app_we,
  input  logic [DATA_WIDTH-1:0]      app_din,
  input  logic [$clog2(ROWS)-1:0]    r_row,
  input  logic [$clog2(COLS)-1:0]    r_col,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic [TAPS*DATA_WIDTH-1:0] tdout,
  output logic [$clog2(ROWS)-1:0]    cur_row,
  output logic [$clog2(COLS)-1:0]    cur_col,
  output logic                       busy,
  output logic                       wr_drop
);

  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned CW = $clog2(COLS);
  localparam logic [RW-1:0] RowLast = RW'(ROWS - 1);
  localparam logic [CW-1:0] ColLast = CW'(COLS - 1);
  localparam logic [DATA_WIDTH-1:0] ChCr = DATA_WIDTH'(8'h0D);
  localparam logic [DATA_WIDTH-1:0] ChLf = DATA_WIDTH'(8'h0A);
  localparam logic [DATA_WIDTH-1:0] ChBs = DATA_WIDTH'(8'h08);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StSweep = 1'b1;

  logic [DATA_WIDTH-1:0] mem [ROWS][COLS];

  logic [0:0]            state_q, state_d;
  logic [RW-1:0]         sr_q, sr_d;
  logic [CW-1:0]         sc_q, sc_d;
  logic [RW-1:0]         cr_q, cr_d;
  logic [CW-1:0]         cc_q, cc_d;
  logic                  drop_q, drop_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [TAPS*DATA_WIDTH-1:0] tdout_q;

  logic                  mem_we;
  logic [RW-1:0]         mem_row;
  logic [CW-1:0]         mem_col;
  logic [DATA_WIDTH-1:0] mem_din;

  logic w_ok;
  logic [RW-1:0] cr_inc;

  assign w_ok = (32'(w_row) < ROWS) && (32'(w_col) < COLS) &&
                !(FILTER_CTRL && ((din == ChCr) || (din == ChLf)));
  assign cr_inc = (cr_q == RowLast) ? '0 : cr_q + RW'(1);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    sc_d    = sc_q;
    cr_d    = cr_q;
    cc_d    = cc_q;
    drop_d  = 1'b0;
    mem_we  = 1'b0;
    mem_row = '0;
    mem_col = '0;
    mem_din = '0;
    if (clr) begin
      // Any request coinciding with a clear is discarded.
      state_d = StSweep;
      sr_d    = '0;
      sc_d    = '0;
      cr_d    = '0;
      cc_d    = '0;
      drop_d  = we | app_we;
    end else if (state_q == StSweep) begin
      mem_we  = 1'b1;
      mem_row = sr_q;
      mem_col = sc_q;
      mem_din = FILL;
      drop_d  = we | app_we;
      if (sc_q == ColLast) begin
        sc_d = '0;
        if (sr_q == RowLast) begin
          sr_d    = '0;
          state_d = StIdle;
        end else begin
          sr_d = sr_q + RW'(1);
        end
      end else begin
        sc_d = sc_q + CW'(1);
      end
    end else if (we) begin
      mem_we  = w_ok;
      mem_row = w_row;
      mem_col = w_col;
      mem_din = din;
      drop_d  = !w_ok || app_we;
    end else if (app_we) begin
      if (app_din == ChCr) begin
        cc_d = '0;
      end else if (app_din == ChLf) begin
        cc_d = '0;
        cr_d = cr_inc;
      end else if (app_din == ChBs) begin
        if (cc_q != '0) cc_d = cc_q - CW'(1);
      end else begin
        mem_we  = 1'b1;
        mem_row = cr_q;
        mem_col = cc_q;
        mem_din = app_din;
        if (cc_q == ColLast) begin
          cc_d = '0;
          cr_d = cr_inc;
        end else begin
          cc_d = cc_q + CW'(1);
        end
      end
    end
  end

  always_comb begin
    dout_d = '0;
    if ((32'(r_row) < ROWS) && (32'(r_col) < COLS)) dout_d = mem[r_row][r_col];
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_row][mem_col] <= mem_din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StSweep;
      sr_q    <= '0;
      sc_q    <= '0;
      cr_q    <= '0;
      cc_q    <= '0;
      drop_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      sc_q    <= sc_d;
      cr_q    <= cr_d;
      cc_q    <= cc_d;
      drop_q  <= drop_d;
      dout_q  <= dout_d;
    end
  end

  for (genvar g = 0; g < TAPS; g++) begin : g_tap
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) tdout_q[g*DATA_WIDTH +: DATA_WIDTH] <= '0;
      else        tdout_q[g*DATA_WIDTH +: DATA_WIDTH] <= mem[0][g];
    end
  end

  assign dout    = dout_q;
  assign tdout   = tdout_q;
  assign cur_row = cr_q;
  assign cur_col = cc_q;
  assign busy    = (state_q == StSweep);
  assign wr_drop = drop_q;

endmodule

// File: tb/tb_text_grid_ram.sv
// Self-checking bench for text_grid_ram: read expectations go through a scoreboard queue.
module tb_text_grid_ram;

  localparam int DW = 8;
  localparam int ROWS = 4;
  localparam int COLS = 32;
  localparam int TAPS = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            clr = 1'b0;
  logic            we = 1'b0;
  logic [1:0]      w_row = '0;
  logic [4:0]      w_col = '0;
  logic [DW-1:0]   din = '0;
  logic            app_we = 1'b0;
  logic [DW-1:0]   app_din = '0;
  logic [1:0]      r_row = '0;
  logic [4:0]      r_col = '0;
  logic [DW-1:0]   dout;
  logic [TAPS*DW-1:0] tdout;
  logic [1:0]      cur_row;
  logic [4:0]      cur_col;
  logic            busy;
  logic            wr_drop;

  int tests_run = 0;
  int tests_failed = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] e;

  text_grid_ram #(
    .DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS), .TAPS(TAPS), .FILL(8'h00), .FILTER_CTRL(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .clr(clr), .we(we), .w_row(w_row), .w_col(w_col), .din(din),
    .app_we(app_we), .app_din(app_din), .r_row(r_row), .r_col(r_col), .dout(dout),
    .tdout(tdout), .cur_row(cur_row), .cur_col(cur_col), .busy(busy), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  // Drives a read address and records the value expected one cycle later.
  task automatic drive_read(input int row, input int col, input logic [DW-1:0] expv);
    r_row = 2'(row);
    r_col = 5'(col);
    exp_q.push_back(expv);
  endtask

  // Counts negedge samples with busy high; returns -1 if the bound expires.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (busy) n = -1;
  endtask

  task automatic test_reset;
    int n;
    tests_run++;
    if (dout !== 0 || tdout !== 0 || cur_row !== 0 || cur_col !== 0 || wr_drop !== 0 ||
        busy !== 1) begin
      tests_failed++;
      $display("FAIL reset_state: dout=%h tdout=%h cur=%0d,%0d drop=%b busy=%b required 0/0/0,0/0/1",
               dout, tdout, cur_row, cur_col, wr_drop, busy);
    end
    @(negedge clk);
    reset = 1'b1;
    count_busy(n);
    tests_run++;
    if (n !== 128) begin
      tests_failed++;
      $display("FAIL reset_busy_len: got %0d cycles required 128", n);
    end
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        drive_read(r, c, 8'h00);
        @(negedge clk);
        e = exp_q.pop_front();
        tests_run++;
        if (dout !== e) begin
          tests_failed++;
          $display("FAIL reset_fill(%0d,%0d): got %h required %h", r, c, dout, e);
        end
      end
    end
  endtask

  task automatic test_direct_write;
    we = 1'b1; w_row = 2; w_col = 5; din = 8'h41;
    @(negedge clk);
    we = 1'b0;
    tests_run++;
    if (wr_drop !== 1'b0) begin
      tests_failed++;
      $display("FAIL direct_no_drop: got %b required 0", wr_drop);
    end
    drive_read(2, 5, 8'h41);
    @(negedge clk);
    e = exp_q.pop_front();
    tests_run++;
    if (dout !== e) begin
      tests_failed++;
      $display("FAIL direct_read: got %h required %h", dout, e);
    end
    we = 1'b1; w_row = 1; w_col = 1; din = 8'h0A;
    @(negedge clk);
    we = 1'b0;
    tests_run++;
    if (wr_drop !== 1'b1) begin
      tests_failed++;
      $display("FAIL filter_drop: got %b required 1", wr_drop);
    end
    drive_read(1, 1, 8'h00);
    @(negedge clk);
    tests_run++;
    if (wr_drop !== 1'b0) begin
      tests_failed++;
      $display("FAIL filter_drop_pulse: got %b required 0", wr_drop);
    end
    e = exp_q.pop_front();
    tests_run++;
    if (dout !== e) begin
      tests_failed++;
      $display("FAIL filter_cell: got %h required %h", dout, e);
    end
  endtask

  task automatic test_append_wrap;
    for (int i = 0; i < 33; i++) begin
      app_we = 1'b1; app_din = 8'h42;
      @(negedge clk);
    end
    app_we = 1'b0;
    tests_run++;
    if (cur_row !== 1 || cur_col !== 1) begin
      tests_failed++;
      $display("FAIL append_cursor: got %0d,%0d required 1,1", cur_row, cur_col);
    end
    drive_read(1, 0, 8'h42);
    @(negedge clk);
    e = exp_q.pop_front();
    tests_run++;
    if (dout !== e) begin
      tests_failed++;
      $display("FAIL append_wrap_cell: got %h required %h", dout, e);
    end
    drive_read(0, 31, 8'h42);
    @(negedge clk);
    e = exp_q.pop_front();
    tests_run++;
    if (dout !== e) begin
      tests_failed++;
      $display("FAIL append_last_col: got %h required %h", dout, e);
    end
    tests_run++;
    if (tdout !== 16'h4242) begin
      tests_failed++;
      $display("FAIL append_taps: got %h required 4242", tdout);
    end
  endtask

  task automatic test_control_codes;
    logic [DW-1:0] codes [6];
    int exp_r [6];
    int exp_c [6];
    int n;
    codes = '{8'h41, 8'h42, 8'h08, 8'h0D, 8'h0A, 8'h08};
    exp_r = '{0, 0, 0, 0, 1, 1};
    exp_c = '{1, 2, 1, 0, 0, 0};
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    tests_run++;
    if (cur_row !== 0 || cur_col !== 0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL clr_cursor: got %0d,%0d busy=%b required 0,0 busy=1", cur_row, cur_col, busy);
    end
    count_busy(n);
    tests_run++;
    if (n !== 128) begin
      tests_failed++;
      $display("FAIL clr_busy_len: got %0d required 128", n);
    end
    for (int i = 0; i < 6; i++) begin
      app_we = 1'b1; app_din = codes[i];
      @(negedge clk);
      app_we = 1'b0;
      tests_run++;
      if (cur_row !== 2'(exp_r[i]) || cur_col !== 5'(exp_c[i]) || wr_drop !== 1'b0) begin
        tests_failed++;
        $display("FAIL ctrl_cursor[%0d]: got %0d,%0d drop=%b required %0d,%0d drop=0",
                 i, cur_row, cur_col, wr_drop, exp_r[i], exp_c[i]);
      end
    end
    for (int c = 0; c < 3; c++) begin
      drive_read(0, c, (c == 0) ? 8'h41 : (c == 1) ? 8'h42 : 8'h00);
      @(negedge clk);
      e = exp_q.pop_front();
      tests_run++;
      if (dout !== e) begin
        tests_failed++;
        $display("FAIL ctrl_cell(0,%0d): got %h required %h", c, dout, e);
      end
    end
  endtask

  task automatic test_conflict_and_sweep;
    int n;
    we = 1'b1; w_row = 3; w_col = 3; din = 8'h55;
    app_we = 1'b1; app_din = 8'h66;
    @(negedge clk);
    we = 1'b0; app_we = 1'b0;
    tests_run++;
    if (wr_drop !== 1'b1 || cur_row !== 1 || cur_col !== 0) begin
      tests_failed++;
      $display("FAIL conflict: drop=%b cur=%0d,%0d required drop=1 cur=1,0", wr_drop, cur_row, cur_col);
    end
    drive_read(3, 3, 8'h55);
    @(negedge clk);
    e = exp_q.pop_front();
    tests_run++;
    if (dout !== e) begin
      tests_failed++;
      $display("FAIL conflict_cell: got %h required %h", dout, e);
    end
    drive_read(1, 0, 8'h00);
    @(negedge clk);
    e = exp_q.pop_front();
    tests_run++;
    if (dout !== e) begin
      tests_failed++;
      $display("FAIL conflict_append_cell: got %h required %h", dout, e);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    we = 1'b1; w_row = 0; w_col = 0; din = 8'h77;
    @(negedge clk);
    we = 1'b0;
    tests_run++;
    if (wr_drop !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL sweep_drop: drop=%b busy=%b required 1/1", wr_drop, busy);
    end
    count_busy(n);
    tests_run++;
    if (n < 0) begin
      tests_failed++;
      $display("FAIL sweep_timeout: busy did not fall, required idle");
    end
    drive_read(0, 0, 8'h00);
    @(negedge clk);
    e = exp_q.pop_front();
    tests_run++;
    if (dout !== e) begin
      tests_failed++;
      $display("FAIL sweep_drop_cell: got %h required %h", dout, e);
    end
  endtask

  task automatic test_reset_mid_sweep;
    int n;
    we = 1'b1; w_row = 3; w_col = 3; din = 8'h5A;
    app_we = 1'b1; app_din = 8'h43;
    @(negedge clk);
    we = 1'b0; app_we = 1'b0;
    r_row = 3; r_col = 3;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 40; i++) @(negedge clk);
    tests_run++;
    if (dout !== 8'h5A) begin
      tests_failed++;
      $display("FAIL mid_sweep_prereset_dout: got %h required 5a", dout);
    end
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (dout !== 0 || tdout !== 0 || cur_row !== 0 || cur_col !== 0 || wr_drop !== 0 ||
        busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_sweep_reset: dout=%h tdout=%h cur=%0d,%0d drop=%b busy=%b required 0/0/0,0/0/1",
               dout, tdout, cur_row, cur_col, wr_drop, busy);
    end
    @(negedge clk);
    reset = 1'b1;
    count_busy(n);
    tests_run++;
    if (n !== 128) begin
      tests_failed++;
      $display("FAIL mid_sweep_busy_len: got %0d required 128", n);
    end
    drive_read(3, 3, 8'h00);
    @(negedge clk);
    e = exp_q.pop_front();
    tests_run++;
    if (dout !== e) begin
      tests_failed++;
      $display("FAIL mid_sweep_cell: got %h required %h", dout, e);
    end
  endtask

  initial begin
    #12;
    test_reset();
    test_direct_write();
    test_append_wrap();
    test_control_codes();
    test_conflict_and_sweep();
    test_reset_mid_sweep();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_leftover: got %0d entries required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
